// File: rtl/project2_alu_v_pkg.sv
// rtl/project2_alu_v_pkg.sv - shared ALU control codes, aluop classes and funcCode values
package project2_alu_v_pkg;

  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_NOR = 4'b1100,
    ALU_ERR = 4'b1111
  } alu_ctl_e;

  localparam logic [1:0] ALUOP_MEM     = 2'd0;
  localparam logic [1:0] ALUOP_LOGIC   = 2'd1;
  localparam logic [1:0] ALUOP_RTYPE   = 2'd2;
  localparam logic [1:0] ALUOP_INVALID = 2'd3;

  localparam logic [9:0] FUNC_ADD = 10'd0;
  localparam logic [9:0] FUNC_OR  = 10'd1;
  localparam logic [9:0] FUNC_SLT = 10'd2;
  localparam logic [9:0] FUNC_AND = 10'd7;
  localparam logic [9:0] FUNC_SUB = 10'd256;
  localparam logic [9:0] FUNC_NOR = 10'd263;

  typedef struct packed {
    logic [7:0] result;
    logic       zero;
    logic       carryout;
    logic       overflow;
  } alu_out_t;

  localparam alu_out_t ALU_OUT_RESET = '{result: 8'd0, zero: 1'b0, carryout: 1'b0, overflow: 1'b0};

  // The adder runs in subtract mode for both SUB and SLT, since SLT is derived from a-b.
  function automatic logic uses_subtract(input alu_ctl_e ctl);
    return (ctl == ALU_SUB) || (ctl == ALU_SLT);
  endfunction

endpackage

// File: rtl/project2_alu_v_cntrl.sv
// rtl/project2_alu_v_cntrl.sv - combinational (aluop, funcCode) to ALU control decode
module project2_alu_v_cntrl
  import project2_alu_v_pkg::*;
(
  input  logic [1:0] aluop,
  input  logic [9:0] funcCode,
  output alu_ctl_e   alu_ctl
);

  always_comb begin
    alu_ctl = ALU_ERR;
    unique case (aluop)
      ALUOP_MEM: alu_ctl = ALU_ADD;
      ALUOP_LOGIC: begin
        // Anything not recognised as a logic op is treated as a branch compare.
        unique case (funcCode)
          FUNC_AND: alu_ctl = ALU_AND;
          FUNC_OR:  alu_ctl = ALU_OR;
          FUNC_NOR: alu_ctl = ALU_NOR;
          default:  alu_ctl = ALU_SUB;
        endcase
      end
      ALUOP_RTYPE: begin
        unique case (funcCode)
          FUNC_ADD: alu_ctl = ALU_ADD;
          FUNC_SUB: alu_ctl = ALU_SUB;
          FUNC_SLT: alu_ctl = ALU_SLT;
          default:  alu_ctl = ALU_ERR;
        endcase
      end
      default: alu_ctl = ALU_ERR;
    endcase
  end

endmodule

// File: rtl/project2_alu_v_top.sv
// rtl/project2_alu_v_top.sv - 8-bit ALU with registered result and flags
module project2_alu_v_top
  import project2_alu_v_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] aluop,
  input  logic [9:0] funcCode,
  input  logic [7:0] a,
  input  logic [7:0] b,
  output logic [7:0] result,
  output logic       zero,
  output logic       carryout,
  output logic       overflow
);

  alu_ctl_e   alu_ctl;
  logic       sub_mode;
  logic [7:0] b_in;
  logic [8:0] sum;
  logic       add_ovf;
  alu_out_t   nxt;
  alu_out_t   q;

  project2_alu_v_cntrl u_cntrl (
    .aluop    (aluop),
    .funcCode (funcCode),
    .alu_ctl  (alu_ctl)
  );

  assign sub_mode = uses_subtract(alu_ctl);
  assign b_in     = sub_mode ? ~b : b;
  assign sum      = {1'b0, a} + {1'b0, b_in} + {8'd0, sub_mode};
  assign add_ovf  = (a[7] == b_in[7]) && (sum[7] != a[7]);

  always_comb begin
    nxt = ALU_OUT_RESET;
    unique case (alu_ctl)
      ALU_AND: nxt.result = a & b;
      ALU_OR:  nxt.result = a | b;
      ALU_NOR: nxt.result = ~(a | b);
      ALU_ADD, ALU_SUB: begin
        nxt.result   = sum[7:0];
        nxt.carryout = sum[8];
        nxt.overflow = add_ovf;
      end
      // Signed less-than: the sign of a-b is wrong exactly when a-b overflowed.
      ALU_SLT: nxt.result = {7'd0, sum[7] ^ add_ovf};
      default: nxt.result = 8'd0;
    endcase
    nxt.zero = (nxt.result == 8'd0);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      q <= ALU_OUT_RESET;
    end else begin
      q <= nxt;
    end
  end

  assign result   = q.result;
  assign zero     = q.zero;
  assign carryout = q.carryout;
  assign overflow = q.overflow;

endmodule

// File: tb/tb_project2_alu_v_top.sv
// tb/tb_project2_alu_v_top.sv - directed and randomized self-checking bench for project2_alu_v_top
module tb_project2_alu_v_top;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] aluop;
  logic [9:0] funcCode;
  logic [7:0] a;
  logic [7:0] b;
  logic [7:0] result;
  logic       zero;
  logic       carryout;
  logic       overflow;

  int errors = 0;
  int checks = 0;

  project2_alu_v_top dut (
    .clk      (clk),
    .reset    (reset),
    .aluop    (aluop),
    .funcCode (funcCode),
    .a        (a),
    .b        (b),
    .result   (result),
    .zero     (zero),
    .carryout (carryout),
    .overflow (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [7:0] er, input logic ez,
                         input logic ec, input logic ev);
    chk({tag, ".result"}, {24'd0, result}, {24'd0, er});
    chk({tag, ".zero"}, {31'd0, zero}, {31'd0, ez});
    chk({tag, ".carry"}, {31'd0, carryout}, {31'd0, ec});
    chk({tag, ".ovf"}, {31'd0, overflow}, {31'd0, ev});
  endtask

  // Drive one operation, let it be captured at the next edge, then check 1 ns later.
  task automatic step(input string tag, input logic [1:0] op, input logic [9:0] fc,
                      input logic [7:0] ia, input logic [7:0] ib, input logic [7:0] er,
                      input logic ez, input logic ec, input logic ev);
    aluop = op; funcCode = fc; a = ia; b = ib;
    @(posedge clk); #1;
    chk_all(tag, er, ez, ec, ev);
  endtask

  // Reference model built from integer arithmetic on the operation's meaning.
  function automatic logic [10:0] model(input logic [1:0] op, input logic [9:0] fc,
                                        input logic [7:0] ia, input logic [7:0] ib);
    int ua, ub, sa, sb, r, s;
    bit c, v;
    string kind;
    ua = int'(ia); ub = int'(ib);
    sa = int'($signed(ia)); sb = int'($signed(ib));
    c = 0; v = 0; r = 0;
    if (op == 2'd0) kind = "add";
    else if (op == 2'd1) kind = (fc == 10'd7) ? "and" : (fc == 10'd1) ? "or" :
                                (fc == 10'd263) ? "nor" : "sub";
    else if (op == 2'd2) kind = (fc == 10'd0) ? "add" : (fc == 10'd256) ? "sub" :
                                (fc == 10'd2) ? "slt" : "err";
    else kind = "err";
    case (kind)
      "add": begin r = ua + ub; c = r > 255; s = sa + sb; v = (s > 127) || (s < -128); end
      "sub": begin r = ua + (255 - ub) + 1; c = r > 255; s = sa - sb; v = (s > 127) || (s < -128); end
      "slt": r = (sa < sb) ? 1 : 0;
      "and": r = ua & ub;
      "or":  r = ua | ub;
      "nor": r = 255 - (ua | ub);
      default: r = 0;
    endcase
    r = r % 256;
    return {r[7:0], r == 0, c, v};
  endfunction

  initial begin
    logic [10:0] exp;
    logic [1:0]  op;
    logic [9:0]  fc;
    logic [7:0]  ia, ib;
    logic [9:0]  fcs [8];
    fcs[0] = 10'd0; fcs[1] = 10'd1; fcs[2] = 10'd2; fcs[3] = 10'd7;
    fcs[4] = 10'd256; fcs[5] = 10'd263; fcs[6] = 10'd8; fcs[7] = 10'd3;

    reset = 1'b1; aluop = 2'd0; funcCode = 10'd0; a = 8'd7; b = 8'd5;
    repeat (2) @(posedge clk);
    #1;
    chk_all("reset", 8'd0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;

    step("first_add", 2'd0, 10'd0, 8'd7, 8'd5, 8'd12, 0, 0, 0);
    step("and", 2'd1, 10'd7, 8'd7, 8'd5, 8'd5, 0, 0, 0);
    step("or", 2'd1, 10'd1, 8'd7, 8'd5, 8'd7, 0, 0, 0);
    step("nor", 2'd1, 10'd263, 8'd7, 8'd5, 8'd248, 0, 0, 0);
    step("radd", 2'd2, 10'd0, 8'd23, 8'd13, 8'd36, 0, 0, 0);
    step("rsub", 2'd2, 10'd256, 8'd23, 8'd13, 8'd10, 0, 1, 0);
    step("slt_t", 2'd2, 10'd2, 8'd2, 8'd7, 8'd1, 0, 0, 0);
    step("slt_f", 2'd2, 10'd2, 8'd7, 8'd2, 8'd0, 1, 0, 0);
    step("beq", 2'd1, 10'd8, 8'd7, 8'd5, 8'd2, 0, 1, 0);
    step("slt_sgn", 2'd2, 10'd2, 8'h80, 8'h01, 8'd1, 0, 0, 0);
    step("add_ovf", 2'd0, 10'd0, 8'h7F, 8'h01, 8'h80, 0, 0, 1);
    step("sub_zero", 2'd2, 10'd256, 8'd5, 8'd5, 8'd0, 1, 1, 0);
    step("err3", 2'd3, 10'd3, 8'd7, 8'd5, 8'd0, 1, 0, 0);
    step("err_fc5", 2'd2, 10'd5, 8'd7, 8'd5, 8'd0, 1, 0, 0);
    step("sub_ovf", 2'd2, 10'd256, 8'h80, 8'h01, 8'h7F, 0, 1, 1);
    step("add_carry", 2'd0, 10'd0, 8'hFF, 8'h01, 8'h00, 1, 1, 0);

    // Outputs must hold while inputs wiggle between edges.
    step("hold_pre", 2'd2, 10'd0, 8'd23, 8'd13, 8'd36, 0, 0, 0);
    aluop = 2'd3; a = 8'd0; b = 8'd0; #2;
    chk_all("hold", 8'd36, 0, 0, 0);

    // Reset pulsed between edges has no effect.
    reset = 1'b1; #2;
    chk_all("async_rst_ignored", 8'd36, 0, 0, 0);
    reset = 1'b0;

    // Reset priority over a valid ADD, then the sum one edge after release.
    aluop = 2'd0; funcCode = 10'd0; a = 8'd23; b = 8'd13; reset = 1'b1;
    @(posedge clk); #1;
    chk_all("rst_prio", 8'd0, 0, 0, 0);
    reset = 1'b0;
    @(posedge clk); #1;
    chk_all("rst_release", 8'd36, 0, 0, 0);

    for (int i = 0; i < 400; i++) begin
      op = 2'($urandom_range(0, 3));
      fc = fcs[$urandom_range(0, 7)];
      if ($urandom_range(0, 3) == 0) fc = 10'($urandom);
      ia = 8'($urandom);
      ib = 8'($urandom);
      if ($urandom_range(0, 7) == 0) ib = ia;
      exp = model(op, fc, ia, ib);
      step($sformatf("rnd%0d", i), op, fc, ia, ib, exp[10:3], exp[2], exp[1], exp[0]);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
